// File: rtl/mac_tbl_pkg.sv
// rtl/mac_tbl_pkg.sv - shared FSM encoding and table entry layout for the MAC table engine
package mac_tbl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_D,
        ST_RD_S,
        ST_LEARN,
        ST_RESP
    } state_t;

    localparam int MAC_W        = 48;
    localparam int ENT_MAC_LSB  = 0;
    localparam int ENT_PORT_LSB = MAC_W;
    localparam int GROUP_BIT    = 40;

    // Entry is {stamp, port, mac}; stamp is absent when age_w is 0.
    function automatic int ent_stamp_lsb(input int port_num);
        return MAC_W + port_num;
    endfunction

    function automatic int entry_width(input int port_num, input int age_w);
        return MAC_W + port_num + age_w;
    endfunction

endpackage

// File: rtl/mac_tbl_engine_if.sv
// rtl/mac_tbl_engine_if.sv - request/result bundle between the port arbiter and the MAC table engine
interface mac_tbl_engine_if #(
    parameter int PORT_NUM        = 4,
    parameter int HASH_DATA_WIDTH = 12
);
    logic [PORT_NUM-1:0]        i_dmac_port;
    logic [HASH_DATA_WIDTH-1:0] i_dmac_hash_key;
    logic [47:0]                i_dmac;
    logic                       i_dmac_vld;
    logic [HASH_DATA_WIDTH-1:0] i_smac_hash_key;
    logic [47:0]                i_smac;
    logic                       i_smac_vld;
    logic [PORT_NUM-1:0]        o_tx_port;
    logic                       o_tx_port_vld;
    logic                       o_learn_collision;
    logic [15:0]                o_drop_cnt;
    logic                       o_busy;

    modport master (
        output i_dmac_port, i_dmac_hash_key, i_dmac, i_dmac_vld,
               i_smac_hash_key, i_smac, i_smac_vld,
        input  o_tx_port, o_tx_port_vld, o_learn_collision, o_drop_cnt, o_busy
    );

    modport slave (
        input  i_dmac_port, i_dmac_hash_key, i_dmac, i_dmac_vld,
               i_smac_hash_key, i_smac, i_smac_vld,
        output o_tx_port, o_tx_port_vld, o_learn_collision, o_drop_cnt, o_busy
    );
endinterface

// File: rtl/mac_tbl_ram.sv
// rtl/mac_tbl_ram.sv - simple dual-port table RAM, one read and one write port, 1-cycle read latency
module mac_tbl_ram #(
    parameter int AW = 12,
    parameter int DW = 52
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mac_tbl_engine.sv
// rtl/mac_tbl_engine.sv - MAC table lookup/learn engine; entry aging enabled by MAC_AGING_EN
module mac_tbl_engine
    import mac_tbl_pkg::*;
#(
    parameter int PORT_NUM        = 4,
    parameter int HASH_DATA_WIDTH = 12
`ifdef MAC_AGING_EN
    ,
    parameter int AGE_W           = 4,
    parameter int AGE_PERIOD      = 250000000,
    parameter int AGE_LIMIT       = 2
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mac_tbl_engine_if.slave  bus
);
    localparam int DEPTH = 2**HASH_DATA_WIDTH;
`ifdef MAC_AGING_EN
    localparam int EW        = entry_width(PORT_NUM, AGE_W);
    localparam int STAMP_LSB = ent_stamp_lsb(PORT_NUM);
`else
    localparam int EW        = entry_width(PORT_NUM, 0);
`endif

    typedef struct packed {
        logic [PORT_NUM-1:0]        src;
        logic [HASH_DATA_WIDTH-1:0] dhash;
        logic [MAC_W-1:0]           dmac;
        logic [HASH_DATA_WIDTH-1:0] shash;
        logic [MAC_W-1:0]           smac;
        logic                       svld;
    } req_t;

    req_t                       req_in, act, pend;
    logic                       pend_vld;
    state_t                     state, state_nxt;
    logic [DEPTH-1:0]           valid;
    logic [HASH_DATA_WIDTH-1:0] rd_addr;
    logic [EW-1:0]              rd_data, wr_data;
    logic                       wr_en, collision;
    logic [MAC_W-1:0]           ent_mac;
    logic [PORT_NUM-1:0]        ent_port, dport_q, result, tx_port;
    logic                       ent_stale, d_hit, dhit_q, learn_ok, s_free, tx_vld;
    logic                       req, pend_load, drain, drop;
    logic [15:0]                drop_cnt;

    assign req_in = '{src:   bus.i_dmac_port,     dhash: bus.i_dmac_hash_key,
                      dmac:  bus.i_dmac,          shash: bus.i_smac_hash_key,
                      smac:  bus.i_smac,          svld:  bus.i_smac_vld};
    assign req    = bus.i_dmac_vld;

    // A request arriving in IDLE while pending is still full queues behind it.
    assign drain     = pend_vld && (state == ST_IDLE || state == ST_RESP);
    assign pend_load = req && ((state == ST_IDLE) ? pend_vld : (!pend_vld || state == ST_RESP));
    assign drop      = req && (state != ST_IDLE) && pend_vld && (state != ST_RESP);

    assign ent_mac  = rd_data[ENT_MAC_LSB +: MAC_W];
    assign ent_port = rd_data[ENT_PORT_LSB +: PORT_NUM];

`ifdef MAC_AGING_EN
    logic [AGE_W-1:0] epoch;
    logic [31:0]      age_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            age_cnt <= '0;
            epoch   <= '0;
        end else if (age_cnt == 32'(AGE_PERIOD - 1)) begin
            age_cnt <= '0;
            epoch   <= epoch + 1'b1;
        end else begin
            age_cnt <= age_cnt + 32'd1;
        end
    end

    assign ent_stale = (AGE_W'(epoch - rd_data[STAMP_LSB +: AGE_W]) >= AGE_W'(AGE_LIMIT));
    assign wr_data   = {epoch, act.src, act.smac};
`else
    assign ent_stale = 1'b0;
    assign wr_data   = {act.src, act.smac};
`endif

    assign rd_addr   = (state == ST_RD_S) ? act.shash : act.dhash;
    assign d_hit     = valid[act.dhash] && (ent_mac == act.dmac) && !ent_stale;
    assign learn_ok  = act.svld && !act.smac[GROUP_BIT] && (act.smac != '0);
    assign s_free    = !valid[act.shash] || (ent_mac == act.smac) || ent_stale;
    assign wr_en     = (state == ST_LEARN) && learn_ok && s_free;
    assign collision = (state == ST_LEARN) && learn_ok && !s_free;
    assign result    = (act.dmac[GROUP_BIT] || !dhit_q) ? ~act.src : (dport_q & ~act.src);

    mac_tbl_ram #(.AW(HASH_DATA_WIDTH), .DW(EW)) u_ram (
        .clk     (i_clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (act.shash),
        .wr_data (wr_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pend_vld || req) state_nxt = ST_RD_D;
            ST_RD_D:  state_nxt = ST_RD_S;
            ST_RD_S:  state_nxt = ST_LEARN;
            ST_LEARN: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = pend_vld ? ST_RD_D : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            dhit_q   <= 1'b0;
            dport_q  <= '0;
            tx_port  <= '0;
            tx_vld   <= 1'b0;
            drop_cnt <= '0;
            valid    <= '0;
        end else begin
            if (drain) begin
                act <= pend;
            end else if (state == ST_IDLE && req) begin
                act <= req_in;
            end
            if (pend_load) begin
                pend     <= req_in;
                pend_vld <= 1'b1;
            end else if (drain) begin
                pend_vld <= 1'b0;
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (state == ST_RD_S) begin
                dhit_q  <= d_hit;
                dport_q <= ent_port;
            end
            if (state == ST_LEARN) begin
                tx_port <= result;
            end
            tx_vld <= (state == ST_LEARN);
            if (wr_en) begin
                valid[act.shash] <= 1'b1;
            end
        end
    end

    assign bus.o_tx_port         = tx_port;
    assign bus.o_tx_port_vld     = tx_vld;
    assign bus.o_learn_collision = collision;
    assign bus.o_drop_cnt        = drop_cnt;
    assign bus.o_busy            = (state != ST_IDLE);

endmodule

// File: doc/mac_tbl_engine.md
# mac_tbl_engine

Single-pipeline MAC address table responder placed behind the port-request arbiter. It consumes one arbitrated lookup request at a time, carrying the source port, the DMAC with its hash, and the SMAC with its hash. It learns the SMAC into a direct-mapped hash table, resolves the DMAC to an egress port bitmap, and returns a single-cycle result pulse to the arbiter, which routes it back to the requesting port.

## Interface
- PORT_NUM, 4, number of switch ports (bitmap width)
- HASH_DATA_WIDTH, 12, hash width; table depth = 2^HASH_DATA_WIDTH
- AGE_W, 4, entry timestamp width (aging builds only)
- AGE_PERIOD, 250000000, cycles per aging epoch (aging builds only)
- AGE_LIMIT, 2, epochs after which an entry is stale (aging builds only)
- i_clk  in  1  core clock, 250 MHz
- i_rst  in  1  asynchronous, active-high reset
- i_dmac_port  in  PORT_NUM  one-hot source port of the request
- i_dmac_hash_key  in  HASH_DATA_WIDTH  DMAC hash
- i_dmac  in  48  DMAC
- i_dmac_vld  in  1  request strobe; all request fields are sampled on this strobe
- i_smac_hash_key  in  HASH_DATA_WIDTH  SMAC hash
- i_smac  in  48  SMAC
- i_smac_vld  in  1  SMAC valid; sampled with i_dmac_vld; low means no learning
- o_tx_port  out  PORT_NUM  egress bitmap
- o_tx_port_vld  out  1  one-cycle result strobe
- o_learn_collision  out  1  one-cycle pulse when learning is refused
- o_drop_cnt  out  16  count of dropped requests, saturating
- o_busy  out  1  FSM not in IDLE

## Operation
- Table layout:
  - Per entry: mac[47:0], port[PORT_NUM-1:0], plus stamp[AGE_W-1:0] in aging builds.
  - Valid bits are held in a separate flop vector, cleared by i_rst.
- FSM states IDLE, RD_D, RD_S, LEARN, RESP:
  - IDLE -> RD_D on an accepted request.
  - RD_D: issue read at the DMAC hash.
  - RD_S: capture the DMAC entry; issue read at the SMAC hash.
  - LEARN: capture the SMAC entry; perform the learning write.
  - RESP: drive the result. Next state is RD_D if the pending slot is full, else IDLE.
- Buffering: one active request register plus one pending register.
  - While the FSM is not IDLE, an incoming request loads pending if pending is empty or is being drained in that same RESP cycle.
  - Otherwise the request is dropped and o_drop_cnt increments.
- DMAC hit: valid, mac equal to DMAC, and not stale.
- Result:
  - If DMAC[40]=1 (group address) or the lookup misses: o_tx_port = all-ones & ~src.
  - On a hit: o_tx_port = entry.port & ~src. An all-zero result (same-port filter) is still strobed.
- Learning conditions: i_smac_vld sampled high, SMAC[40]=0, SMAC≠0.
  - If the entry is invalid, the mac matches, or the entry is stale: write {SMAC, src, epoch} and set valid.
  - Otherwise no write and o_learn_collision pulses during LEARN.
- Same-hash DMAC/SMAC in one request: the DMAC read precedes the write, so the result reflects the pre-learn table.

## Timing
- Request sampled at the end of cycle T. RD_D=T+1, RD_S=T+2, LEARN=T+3, RESP=T+4.
- o_tx_port_vld is high during T+4 only. Latency is 4 cycles.
- A pending request restarts at T+5, with its response at T+8. Sustained throughput is one request per 4 cycles.
- RAM read latency is 1 cycle. The write in LEARN is visible to any read issued at or after T+4.
- Reset values: o_tx_port=0, o_tx_port_vld=0, o_learn_collision=0, o_drop_cnt=0, o_busy=0, FSM=IDLE, pending empty, all valid bits 0, epoch=0.
- Reset mid-request: the request is discarded and no response is issued.
- o_drop_cnt saturates at 0xFFFF.

## Configuration
- MAC_AGING_EN defined:
  - A cycle counter advances the epoch every AGE_PERIOD cycles; the epoch wraps modulo 2^AGE_W.
  - An entry is stale when (epoch − stamp) mod 2^AGE_W ≥ AGE_LIMIT.
  - A SMAC hit refreshes the stamp.
  - Entries untouched for 2^AGE_W or more epochs alias as fresh. This is accepted behaviour.
- MAC_AGING_EN undefined: no epoch logic and no stamp field; entries never become stale.

## Structure
- mac_tbl_pkg holds the FSM state encoding, the entry field offsets and width, and the group-bit index (40).
- Sub-module mac_tbl_ram: simple dual-port RAM, one read port and one write port, 1-cycle read latency, no reset. Valid bits stay in mac_tbl_engine.

## Test plan
- Post-reset miss: src 4'b0001, DMAC 00:11:22:33:44:55 (hash 0x010), SMAC 02:00:00:00:00:AA (hash 0x020). Expect o_tx_port=4'b1110 at T+4; entry 0x020 learned on port 0001.
- Hit: src 4'b0100, DMAC 02:00:00:00:00:AA (hash 0x020). Expect o_tx_port=4'b0001.
- Same-port filter: src 4'b0001, DMAC 02:00:00:00:00:AA. Expect o_tx_port_vld=1 with o_tx_port=4'b0000.
- Broadcast: DMAC FF:FF:FF:FF:FF:FF from src 4'b0010. Expect 4'b1101, and the SMAC is still learned.
- Collision: SMAC 02:00:00:00:00:BB with hash 0x020 from src 4'b1000. Expect an o_learn_collision pulse at T+3, and a later lookup of ..AA still returns 4'b0001.
- Back-to-back: requests on 3 consecutive cycles. Expect responses at T+4 and T+8, the third request dropped, o_drop_cnt=1.
